// File: rtl/lcd_reader_if.sv
// Controller-side handshake between the LCD control logic and the read engine.
//   rd_req/rd_rs    : request and register select (0 = BF/AC, 1 = data)
//   rd_ready        : engine idle, request accepted this cycle
//   rd_valid        : one-cycle pulse, rd_data valid
//   rd_data, bf, ac : last sampled byte, busy flag and address counter
//   poll_*          : busy-flag poll handshake (only with LCD_BF_POLL_EN)
// Optional feature macro: LCD_BF_POLL_EN.
interface lcd_reader_if;
  logic       rd_req;
  logic       rd_rs;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       bf;
  logic [6:0] ac;
`ifdef LCD_BF_POLL_EN
  logic       poll_req;
  logic       poll_done;
  logic       poll_timeout;

  modport master (
    output rd_req, rd_rs, poll_req,
    input  rd_ready, rd_valid, rd_data, bf, ac, poll_done, poll_timeout
  );
  modport slave (
    input  rd_req, rd_rs, poll_req,
    output rd_ready, rd_valid, rd_data, bf, ac, poll_done, poll_timeout
  );
`else
  modport master (
    output rd_req, rd_rs,
    input  rd_ready, rd_valid, rd_data, bf, ac
  );
  modport slave (
    input  rd_req, rd_rs,
    output rd_ready, rd_valid, rd_data, bf, ac
  );
`endif
endinterface

// File: rtl/lcd_reader.sv
// HD44780 read-side bus engine: runs RW=1 read cycles (BF/AC or data) and
// returns the sampled byte through a req/ready/valid handshake.
// Ports:
//   clock, internal_reset : clock, synchronous active-high reset
//   rd                    : controller handshake (lcd_reader_if.slave)
//   rs, rw, e             : LCD control pins
//   d_in                  : LCD data pins, pad input side
//   bus_rel               : 1 = reader owns the bus, write engine drivers off
// Optional feature macro: LCD_BF_POLL_EN (busy-flag polling, adds POLL_MAX).
module lcd_reader #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned T_AS_NS  = 60,
  parameter int unsigned T_EH_NS  = 450,
  parameter int unsigned T_AH_NS  = 20,
  parameter int unsigned T_CYC_NS = 1000
`ifdef LCD_BF_POLL_EN
  , parameter int unsigned POLL_MAX = 16
`endif
) (
  input  logic         clock,
  input  logic         internal_reset,
  lcd_reader_if.slave  rd,
  output logic         rs,
  output logic         rw,
  output logic         e,
  input  logic [7:0]   d_in,
  output logic         bus_rel
);

  // Phase lengths in clock cycles, floored, never below one cycle
  localparam int unsigned CLK_MHZ  = CLK_FREQ / 1000000;
  localparam int unsigned N_AS_RAW = CLK_MHZ * T_AS_NS / 1000;
  localparam int unsigned N_EH_RAW = CLK_MHZ * T_EH_NS / 1000;
  localparam int unsigned N_AH_RAW = CLK_MHZ * T_AH_NS / 1000;
  localparam int unsigned N_CY_RAW = CLK_MHZ * T_CYC_NS / 1000;
  localparam int unsigned N_AS  = (N_AS_RAW == 0) ? 1 : N_AS_RAW;
  localparam int unsigned N_EH  = (N_EH_RAW == 0) ? 1 : N_EH_RAW;
  localparam int unsigned N_AH  = (N_AH_RAW == 0) ? 1 : N_AH_RAW;
  localparam int unsigned N_CYC = (N_CY_RAW == 0) ? 1 : N_CY_RAW;
  localparam int          N_RC_RAW = int'(N_CYC) - int'(N_EH) - int'(N_AH);
  localparam int unsigned N_RC  = (N_RC_RAW < 1) ? 1 : unsigned'(N_RC_RAW);
  localparam int unsigned N_M1  = (N_AS > N_EH) ? N_AS : N_EH;
  localparam int unsigned N_M2  = (N_AH > N_RC) ? N_AH : N_RC;
  localparam int unsigned N_MAX = (N_M1 > N_M2) ? N_M1 : N_M2;
  localparam int unsigned CNT_W = $clog2(N_MAX + 1);
`ifdef LCD_BF_POLL_EN
  localparam int unsigned PC_W  = $clog2(POLL_MAX + 1);
`endif

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] EHIGH   = 3'd2;
  localparam logic [2:0] EHOLD   = 3'd3;
  localparam logic [2:0] RECOVER = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rs_lat, rs_lat_nxt;
  logic             rd_ready_q, rd_ready_nxt;
  logic             rd_valid_q, rd_valid_nxt;
  logic [7:0]       rd_data_q, rd_data_nxt;
  logic             bf_q, bf_nxt;
  logic [6:0]       ac_q, ac_nxt;
  logic             rs_q, rs_nxt;
  logic             rw_q, rw_nxt;
  logic             e_q, e_nxt;
  logic             bus_rel_q, bus_rel_nxt;
  logic             accept_c;
`ifdef LCD_BF_POLL_EN
  logic             poll_mode, poll_mode_nxt;
  logic [PC_W-1:0]  poll_cnt, poll_cnt_nxt;
  logic             poll_done_q, poll_done_nxt;
  logic             poll_timeout_q, poll_timeout_nxt;

  assign accept_c = rd_ready_q & (rd.rd_req | rd.poll_req);
`else
  assign accept_c = rd_ready_q & rd.rd_req;
`endif

  // Next-state, phase counter, capture and registered-output decode
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    rs_lat_nxt  = rs_lat;
    rd_data_nxt = rd_data_q;
    bf_nxt      = bf_q;
    ac_nxt      = ac_q;
`ifdef LCD_BF_POLL_EN
    poll_mode_nxt    = poll_mode;
    poll_cnt_nxt     = poll_cnt;
    poll_timeout_nxt = poll_timeout_q;
`endif
    case (state)
      IDLE, DONE: begin
        if (accept_c) begin
          state_nxt  = SETUP;
          rs_lat_nxt = rd.rd_rs;
`ifdef LCD_BF_POLL_EN
          // rd_req has priority; a poll is always a run of BF/AC reads
          poll_mode_nxt = 1'b0;
          if (!rd.rd_req) begin
            poll_mode_nxt    = 1'b1;
            rs_lat_nxt       = 1'b0;
            poll_cnt_nxt     = '0;
            poll_timeout_nxt = 1'b0;
          end
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      SETUP: begin
        if (cnt == CNT_W'(N_AS - 1)) state_nxt = EHIGH;
        else                         cnt_nxt   = cnt + CNT_W'(1);
      end
      EHIGH: begin
        // Sample only at the end of E high, after tDDR has elapsed
        if (cnt == CNT_W'(N_EH - 1)) begin
          state_nxt   = EHOLD;
          rd_data_nxt = d_in;
          if (!rs_lat) begin
            bf_nxt = d_in[7];
            ac_nxt = d_in[6:0];
          end
`ifdef LCD_BF_POLL_EN
          if (poll_mode) poll_cnt_nxt = poll_cnt + PC_W'(1);
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      EHOLD: begin
        if (cnt == CNT_W'(N_AH - 1)) state_nxt = RECOVER;
        else                         cnt_nxt   = cnt + CNT_W'(1);
      end
      RECOVER: begin
        if (cnt == CNT_W'(N_RC - 1)) begin
          state_nxt = DONE;
`ifdef LCD_BF_POLL_EN
          // Keep polling while busy and reads remain; bf_q is the read just done
          if (poll_mode) begin
            if (bf_q && (poll_cnt != PC_W'(POLL_MAX))) state_nxt = SETUP;
            else                                       poll_timeout_nxt = bf_q;
          end
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    rw_nxt       = (state_nxt == SETUP) | (state_nxt == EHIGH) | (state_nxt == EHOLD);
    e_nxt        = (state_nxt == EHIGH);
    bus_rel_nxt  = rw_nxt;
    rs_nxt       = rw_nxt & rs_lat_nxt;
    rd_ready_nxt = (state_nxt == IDLE) | (state_nxt == DONE);
    rd_valid_nxt = (state_nxt == DONE);
`ifdef LCD_BF_POLL_EN
    poll_done_nxt = (state_nxt == DONE) & poll_mode_nxt;
`endif
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (internal_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rs_lat     <= 1'b0;
      rd_ready_q <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      bf_q       <= 1'b1;
      ac_q       <= 7'h00;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      e_q        <= 1'b0;
      bus_rel_q  <= 1'b0;
`ifdef LCD_BF_POLL_EN
      poll_mode      <= 1'b0;
      poll_cnt       <= '0;
      poll_done_q    <= 1'b0;
      poll_timeout_q <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rs_lat     <= rs_lat_nxt;
      rd_ready_q <= rd_ready_nxt;
      rd_valid_q <= rd_valid_nxt;
      rd_data_q  <= rd_data_nxt;
      bf_q       <= bf_nxt;
      ac_q       <= ac_nxt;
      rs_q       <= rs_nxt;
      rw_q       <= rw_nxt;
      e_q        <= e_nxt;
      bus_rel_q  <= bus_rel_nxt;
`ifdef LCD_BF_POLL_EN
      poll_mode      <= poll_mode_nxt;
      poll_cnt       <= poll_cnt_nxt;
      poll_done_q    <= poll_done_nxt;
      poll_timeout_q <= poll_timeout_nxt;
`endif
    end
  end

  assign rd.rd_ready = rd_ready_q;
  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_data  = rd_data_q;
  assign rd.bf       = bf_q;
  assign rd.ac       = ac_q;
`ifdef LCD_BF_POLL_EN
  assign rd.poll_done    = poll_done_q;
  assign rd.poll_timeout = poll_timeout_q;
`endif
  assign rs      = rs_q;
  assign rw      = rw_q;
  assign e       = e_q;
  assign bus_rel = bus_rel_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader: directed and randomized reads checked
// cycle by cycle against a timeline model built from the phase lengths.
module tb_lcd_reader;
  localparam int N_AS  = 6;
  localparam int N_EH  = 45;
  localparam int N_AH  = 2;
  localparam int N_CYC = 100;
  localparam int CAP   = N_AS + N_EH;         // cycle whose closing edge samples d_in
  localparam int RWEND = N_AS + N_EH + N_AH;  // last cycle with rw=1
  localparam int LAT   = N_AS + N_CYC + 1;    // rd_valid cycle
  localparam int RPER  = N_AS + N_CYC;        // one read without DONE

  logic       clock = 1'b0;
  logic       internal_reset;
  logic [7:0] d_in;
  logic       rs, rw, e, bus_rel;

  lcd_reader_if rdi ();

  lcd_reader dut (
    .clock          (clock),
    .internal_reset (internal_reset),
    .rd             (rdi),
    .rs             (rs),
    .rw             (rw),
    .e              (e),
    .d_in           (d_in),
    .bus_rel        (bus_rel)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_data;
  logic       exp_bf;
  logic [6:0] exp_ac;
  logic       exp_to;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_data = 8'h00;
    exp_bf   = 1'b1;
    exp_ac   = 7'h00;
    exp_to   = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, ".rd_data"}, 32'(rdi.rd_data), 32'(exp_data));
    check_eq({tag, ".bf"},      32'(rdi.bf),      32'(exp_bf));
    check_eq({tag, ".ac"},      32'(rdi.ac),      32'(exp_ac));
`ifdef LCD_BF_POLL_EN
    check_eq({tag, ".poll_timeout"}, 32'(rdi.poll_timeout), 32'(exp_to));
`endif
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".e"},        32'(e),            0);
    check_eq({tag, ".rw"},       32'(rw),           0);
    check_eq({tag, ".rs"},       32'(rs),           0);
    check_eq({tag, ".bus_rel"},  32'(bus_rel),      0);
    check_eq({tag, ".rd_ready"}, 32'(rdi.rd_ready), 1);
    check_eq({tag, ".rd_valid"}, 32'(rdi.rd_valid), 0);
    check_regs(tag);
  endtask

  // One read, entered at a falling edge with the engine ready. d_in carries dcap
  // in the sampling cycle and dfill (or random bytes) in every other cycle.
  task automatic do_read(input logic rsel, input bit hold, input logic [7:0] dcap,
                         input logic [7:0] dfill, input bit rnd);
    string t;
    bit    x_e, x_rw, x_dn;
    check_eq("ready_before_req", 32'(rdi.rd_ready), 1);
    rdi.rd_req = 1'b1;
    rdi.rd_rs  = rsel;
`ifdef LCD_BF_POLL_EN
    rdi.poll_req = 1'b1;  // rd_req must win
`endif
    @(posedge clock);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clock);
`ifdef LCD_BF_POLL_EN
      rdi.poll_req = 1'b0;
`endif
      if (k < LAT) begin
        rdi.rd_req = hold ? 1'b1 : 1'($urandom);  // ignored while busy
        rdi.rd_rs  = 1'($urandom);
      end else begin
        rdi.rd_req = hold;
      end
      d_in = (k == CAP) ? dcap : (rnd ? 8'($urandom) : dfill);
      if (k == CAP + 1) begin
        exp_data = dcap;
        if (!rsel) begin
          exp_bf = dcap[7];
          exp_ac = dcap[6:0];
        end
      end
      x_e  = (k >= N_AS + 1) && (k <= CAP);
      x_rw = (k <= RWEND);
      x_dn = (k == LAT);
      t = $sformatf("rd%0d@%0d", rsel, k);
      check_eq({t, ".e"},        32'(e),            32'(x_e));
      check_eq({t, ".rw"},       32'(rw),           32'(x_rw));
      check_eq({t, ".rs"},       32'(rs),           32'(x_rw & rsel));
      check_eq({t, ".bus_rel"},  32'(bus_rel),      32'(x_rw));
      check_eq({t, ".rd_ready"}, 32'(rdi.rd_ready), 32'(x_dn));
      check_eq({t, ".rd_valid"}, 32'(rdi.rd_valid), 32'(x_dn));
`ifdef LCD_BF_POLL_EN
      check_eq({t, ".poll_done"}, 32'(rdi.poll_done), 0);
`endif
      check_regs(t);
    end
  endtask

  task automatic idle_gap(input int n);
    rdi.rd_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_idle($sformatf("gap%0d", i));
    end
  endtask

`ifdef LCD_BF_POLL_EN
  localparam int POLL_MAX = 16;

  // nbusy reads report busy (0x80|index), then d_in = fin
  task automatic do_poll(input int nbusy, input logic [7:0] fin);
    int         nr, last, idx, w;
    logic [7:0] v;
    string      t;
    nr   = (nbusy + 1 < POLL_MAX) ? nbusy + 1 : POLL_MAX;
    last = nr * RPER + 1;
    rdi.poll_req = 1'b1;
    rdi.rd_req   = 1'b0;
    @(posedge clock);
    for (int k = 1; k <= last; k++) begin
      @(negedge clock);
      rdi.poll_req = 1'b0;
      idx  = (k - 1) / RPER;
      w    = (k - 1) % RPER + 1;
      v    = (idx < nbusy) ? (8'h80 | 8'(idx)) : fin;
      d_in = v;
      if (k == 1) exp_to = 1'b0;
      if (w == CAP + 1 && k < last) begin
        v        = ((idx) < nbusy) ? (8'h80 | 8'(idx)) : fin;
        exp_data = v;
        exp_bf   = v[7];
        exp_ac   = v[6:0];
      end
      if (k == last) exp_to = (nbusy >= POLL_MAX);
      t = $sformatf("poll%0d@%0d", nbusy, k);
      check_eq({t, ".e"},  32'(e),  32'((k < last) && (w >= N_AS + 1) && (w <= CAP)));
      check_eq({t, ".rw"}, 32'(rw), 32'((k < last) && (w <= RWEND)));
      check_eq({t, ".rs"}, 32'(rs), 0);
      check_eq({t, ".rd_valid"},  32'(rdi.rd_valid),  32'(k == last));
      check_eq({t, ".poll_done"}, 32'(rdi.poll_done), 32'(k == last));
      check_regs(t);
    end
  endtask
`endif

  initial begin
    internal_reset = 1'b1;
    rdi.rd_req     = 1'b0;
    rdi.rd_rs      = 1'b0;
    d_in           = 8'h00;
`ifdef LCD_BF_POLL_EN
    rdi.poll_req   = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle("reset");
    internal_reset = 1'b0;
    @(negedge clock);
    check_idle("after_reset");

    // BF/AC read of 0x8A
    do_read(1'b0, 1'b0, 8'h8A, 8'h8A, 1'b0);
    idle_gap(2);
    // Preload bf=0/ac=0x05, then a data read leaves them untouched
    do_read(1'b0, 1'b0, 8'h05, 8'h05, 1'b0);
    do_read(1'b1, 1'b0, 8'h48, 8'h48, 1'b0);
    idle_gap(1);
    // Only the last E-high cycle is sampled
    do_read(1'b1, 1'b0, 8'h22, 8'h11, 1'b0);
    idle_gap(1);
    // rd_req held high: back-to-back reads accepted at each DONE
    for (int i = 0; i < 3; i++)
      do_read(1'($urandom), (i < 2), 8'($urandom), 8'h00, 1'b1);
    idle_gap(1);
    // Randomized reads with random idle gaps
    for (int i = 0; i < 6; i++) begin
      do_read(1'($urandom), 1'b0, 8'($urandom), 8'h00, 1'b1);
      idle_gap(int'($urandom_range(0, 3)));
    end

    // Reset during E high (20th cycle) aborts the read
    check_eq("abort_ready", 32'(rdi.rd_ready), 1);
    rdi.rd_req = 1'b1;
    rdi.rd_rs  = 1'b0;
    @(posedge clock);
    for (int k = 1; k <= N_AS + 20; k++) begin
      @(negedge clock);
      rdi.rd_req = 1'b0;
      d_in = 8'h3C;
    end
    check_eq("abort_e_high", 32'(e), 1);
    internal_reset = 1'b1;
    @(negedge clock);
    internal_reset = 1'b0;
    model_reset();
    check_idle("abort");
    for (int k = 0; k < LAT; k++) begin
      @(negedge clock);
      check_eq($sformatf("abort_novalid@%0d", k), 32'(rdi.rd_valid), 0);
      check_eq($sformatf("abort_noe@%0d", k),     32'(e),            0);
    end
    check_idle("abort_end");
    do_read(1'b0, 1'b0, 8'h7F, 8'h7F, 1'b0);

`ifdef LCD_BF_POLL_EN
    idle_gap(1);
    do_poll(3, 8'h03);
    idle_gap(1);
    do_poll(20, 8'h01);
    do_read(1'b1, 1'b0, 8'hA5, 8'h00, 1'b1);
    idle_gap(1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
